report_event_arbiter: RTL
=========================

// Module: report_event_arbiter
//
// PURPOSE
//  Synthesizable event-report concentrator. Shares one report channel between
//  NB_REQ requesters (round-robin): accepts severity+code records, buffers them
//  in a FIFO, presents them on a valid/ready output stream, and keeps
//  info/warning/error counters plus a sticky fatal flag for on-chip status.
//
// PARAMETERS
//  NB_REQ       4   number of requesters (>=2)
//  CODE_WIDTH   16  event code width per requester
//  CNT_WIDTH    16  width of each severity counter (saturating)
//  FIFO_LOG2    3   log2 of FIFO depth (depth = 2**FIFO_LOG2)
//  TS_WIDTH     32  timestamp width (used only with the optional feature)
//
// PORTS
//  clk            in   1                   clock
//  srst           in   1                   synchronous reset, active high
//  req_valid      in   NB_REQ              requester i has a record
//  req_severity   in   2*NB_REQ            slice i: 0 INFO,1 WARNING,2 ERROR,3 FATAL
//  req_code       in   CODE_WIDTH*NB_REQ   slice i: event code
//  req_ready      out  NB_REQ              one-hot (or 0) accept strobe
//  out_valid      out  1                   record available
//  out_ready      in   1                   consumer accepts record
//  out_severity   out  2                   record severity
//  out_src        out  clog2(NB_REQ)       index of originating requester
//  out_code       out  CODE_WIDTH          record code
//  out_timestamp  out  TS_WIDTH            capture time (0 without feature)
//  clr_counters   in   1                   zero all counters this cycle
//  nb_info        out  CNT_WIDTH           accepted INFO count
//  nb_warning     out  CNT_WIDTH           accepted WARNING count
//  nb_error       out  CNT_WIDTH           accepted ERROR count
//  fatal_seen     out  1                   sticky: a FATAL was accepted
//
// BEHAVIOUR
//  - Reset: req_ready=0, out_valid=0, out_* data=0, counters=0, fatal_seen=0,
//    RR pointer=0, FIFO empty, timestamp=0.
//  - Handshake: transfer when valid&ready (both sides). req_ready is combinational
//    from req_valid, RR pointer, FIFO full, fatal_seen; at most one bit high.
//  - Arbitration: search from RR pointer upward (wrap); first valid wins.
//    After a grant to i, pointer <= (i+1) mod NB_REQ; no grant -> pointer held.
//  - Grant only when FIFO not full; a pop in the same cycle does NOT free a slot
//    for that cycle's grant. Empty FIFO -> out_valid=0.
//  - Latency: record accepted in cycle N is visible on out_* at N+1 earliest.
//    Output data stable while out_valid & !out_ready. Order = acceptance order.
//  - Counters increment on acceptance of matching severity; saturate at all-ones.
//    clr_counters with simultaneous acceptance -> that counter = 1, others 0.
//    clr_counters does not clear fatal_seen.
//  - FATAL: record is enqueued, fatal_seen<=1 next cycle; from then req_ready=0
//    for all until srst. FIFO keeps draining normally.
//  - srst mid-operation: FIFO contents discarded, all state to reset values.
//
// CONFIGURATION
//  REPORT_EVENT_ARBITER_TIMESTAMP_EN defined: free-running TS_WIDTH cycle counter
//    (0 after srst, +1 per cycle, wraps); value sampled in the acceptance cycle
//    is stored with the record and driven on out_timestamp.
//  Not defined: no counter, no FIFO storage for it, out_timestamp tied to 0.
//
// STRUCTURE
//  - report_pkg.vh: severity encodings (SEV_INFO..SEV_FATAL), SEV_WIDTH=2.
//  - Sub-module report_event_fifo: sync FIFO, registered output, push/pop/full/
//    empty; record width = 2+clog2(NB_REQ)+CODE_WIDTH[+TS_WIDTH].
//  - Top: RR arbiter, counters, fatal latch, timestamp counter.
//
// TESTING
//  1 Reset: hold srst 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, counters 0.
//  2 Fairness: NB_REQ=4, all valid continuously, out_ready=1 -> sources 0,1,2,3,0,1...
//  3 Full: out_ready=0, req0 posts 10 INFO -> 8 accepted, req_ready0 low after 8,
//    nb_info=8; release out_ready -> remaining 2 accepted, order preserved.
//  4 Saturation/clear: CNT_WIDTH=4, 20 WARNINGs -> nb_warning=15; clr_counters with
//    one WARNING accepted same cycle -> nb_warning=1.
//  5 Fatal: req2 FATAL code 0xDEAD -> fatal_seen=1 next cycle, no further req_ready,
//    record (sev 3, src 2, 0xDEAD) still emerges; srst clears fatal_seen.
//  6 Timestamp (macro on): accept at cycle 5 after reset -> out_timestamp=5.

Source files
------------

// File: rtl/report_event_arbiter_pkg.sv
//==============================================================================
// Module : report_event_arbiter_pkg
// Brief  : Severity encodings and record sizing shared by the report arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package report_event_arbiter_pkg;

    localparam int SEV_WIDTH = 2;

    typedef enum logic [SEV_WIDTH-1:0] {
        SEV_INFO    = 2'd0,
        SEV_WARNING = 2'd1,
        SEV_ERROR   = 2'd2,
        SEV_FATAL   = 2'd3
    } severity_t;

    // Stored record: {severity, source index, code[, timestamp]}
    function automatic int record_width(input int nb_req, input int code_w, input int ts_w);
        return SEV_WIDTH + $clog2(nb_req) + code_w + ts_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/report_event_arbiter_fifo.sv
//==============================================================================
// Module : report_event_arbiter_fifo
// Brief  : Synchronous FIFO holding accepted records; head drives the output.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module report_event_arbiter_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == (ADDR_WIDTH+1)'(c_DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    // Head is masked while empty so the output data reads zero after reset.
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/report_event_arbiter.sv
//==============================================================================
// Module : report_event_arbiter
// Brief  : Round-robin concentrator of severity+code event reports into one
//          FIFO-buffered valid/ready stream, with saturating severity counters
//          and a sticky fatal flag. Optional macro
//          REPORT_EVENT_ARBITER_TIMESTAMP_EN adds a per-record capture time.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module report_event_arbiter
    import report_event_arbiter_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int CODE_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_LOG2  = 3,
    parameter int TS_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic [NB_REQ-1:0]          req_valid,
    input  logic [2*NB_REQ-1:0]        req_severity,
    input  logic [CODE_WIDTH*NB_REQ-1:0] req_code,
    output logic [NB_REQ-1:0]          req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_severity,
    output logic [$clog2(NB_REQ)-1:0]  out_src,
    output logic [CODE_WIDTH-1:0]      out_code,
    output logic [TS_WIDTH-1:0]        out_timestamp,
    input  logic                       clr_counters,
    output logic [CNT_WIDTH-1:0]       nb_info,
    output logic [CNT_WIDTH-1:0]       nb_warning,
    output logic [CNT_WIDTH-1:0]       nb_error,
    output logic                       fatal_seen
);

    localparam int c_SRC_W = $clog2(NB_REQ);
`ifdef REPORT_EVENT_ARBITER_TIMESTAMP_EN
    localparam int c_TS_W  = TS_WIDTH;
`else
    localparam int c_TS_W  = 0;
`endif
    localparam int c_REC_W = record_width(NB_REQ, CODE_WIDTH, c_TS_W);

    logic [c_SRC_W-1:0]    r_ptr;
    logic                  r_fatal_seen;
    logic [CNT_WIDTH-1:0]  r_nb_info;
    logic [CNT_WIDTH-1:0]  r_nb_warning;
    logic [CNT_WIDTH-1:0]  r_nb_error;

    logic                  w_gnt_any;
    logic [c_SRC_W-1:0]    w_gnt_idx;
    logic [SEV_WIDTH-1:0]  w_gnt_sev;
    logic [CODE_WIDTH-1:0] w_gnt_code;
    int                    w_scan;
    logic                  w_accept;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [c_REC_W-1:0]    w_push_rec;
    logic [c_REC_W-1:0]    w_pop_rec;
    logic                  w_inc_info;
    logic                  w_inc_warning;
    logic                  w_inc_error;

    // Scan from the pointer downward in priority so the first valid at or
    // after r_ptr (with wrap) is the last one written, hence the winner.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_sev  = '0;
        w_gnt_code = '0;
        w_scan     = 0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            w_scan = (int'(r_ptr) + k) % NB_REQ;
            if (req_valid[w_scan]) begin
                w_gnt_any  = 1'b1;
                w_gnt_idx  = c_SRC_W'(w_scan);
                w_gnt_sev  = req_severity[w_scan*SEV_WIDTH +: SEV_WIDTH];
                w_gnt_code = req_code[w_scan*CODE_WIDTH +: CODE_WIDTH];
            end
        end
    end

    // A pop in this cycle does not open a slot for this cycle's grant.
    assign w_accept = !srst && w_gnt_any && !w_fifo_full && !r_fatal_seen;

    for (genvar i = 0; i < NB_REQ; i++) begin : g_ready
        assign req_ready[i] = w_accept && (w_gnt_idx == c_SRC_W'(i));
    end

    assign w_inc_info    = w_accept && (w_gnt_sev == SEV_INFO);
    assign w_inc_warning = w_accept && (w_gnt_sev == SEV_WARNING);
    assign w_inc_error   = w_accept && (w_gnt_sev == SEV_ERROR);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_ptr        <= '0;
            r_fatal_seen <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == c_SRC_W'(NB_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            if (w_gnt_sev == SEV_FATAL) r_fatal_seen <= 1'b1;
        end
    end

    // Clear wins over history but still counts an acceptance in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_nb_info    <= '0;
            r_nb_warning <= '0;
            r_nb_error   <= '0;
        end else if (clr_counters) begin
            r_nb_info    <= CNT_WIDTH'(w_inc_info);
            r_nb_warning <= CNT_WIDTH'(w_inc_warning);
            r_nb_error   <= CNT_WIDTH'(w_inc_error);
        end else begin
            if (w_inc_info && (r_nb_info != '1))       r_nb_info    <= r_nb_info + 1'b1;
            if (w_inc_warning && (r_nb_warning != '1)) r_nb_warning <= r_nb_warning + 1'b1;
            if (w_inc_error && (r_nb_error != '1))     r_nb_error   <= r_nb_error + 1'b1;
        end
    end

`ifdef REPORT_EVENT_ARBITER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (srst) r_ts <= '0;
        else      r_ts <= r_ts + 1'b1;
    end

    assign w_push_rec = {w_gnt_sev, w_gnt_idx, w_gnt_code, r_ts};
    assign {out_severity, out_src, out_code, out_timestamp} = w_pop_rec;
`else
    assign w_push_rec = {w_gnt_sev, w_gnt_idx, w_gnt_code};
    assign {out_severity, out_src, out_code} = w_pop_rec;
    assign out_timestamp = {TS_WIDTH{1'b0}};
`endif

    assign out_valid = !w_fifo_empty;
    assign w_pop     = out_valid && out_ready;

    report_event_arbiter_fifo #(
        .DATA_WIDTH (c_REC_W),
        .ADDR_WIDTH (FIFO_LOG2)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (w_accept),
        .push_data (w_push_rec),
        .pop       (w_pop),
        .pop_data  (w_pop_rec),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign nb_info    = r_nb_info;
    assign nb_warning = r_nb_warning;
    assign nb_error   = r_nb_error;
    assign fatal_seen = r_fatal_seen;

endmodule

`default_nettype wire
